// File: rtl/instr_seq_pkg.sv
// Shared widths, opcodes and FSM state encoding for the instruction sequencer.
// The optional SINGLE_STEP_EN macro is consumed by instr_seq itself, not here.
package instr_seq_pkg;

  localparam int ADDR_W = 4;
  localparam int OPC_W  = 4;
  localparam int STEP_W = 3;

  localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Microstep counter sticks at all-ones so long instructions never alias step 0.
  function automatic logic [STEP_W-1:0] satInc(input logic [STEP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/instr_seq_pc_counter.sv
// Program counter for instr_seq: synchronous active-low reset, jump load, and
// increment that wraps naturally at the top of the address space.
module pc_counter
  import instr_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;

  // A jump load wins over increment; the two never coincide in the sequencer.
  always_comb begin
    w_pc_next = r_pc;
    if (i_load) begin
      w_pc_next = i_load_val;
    end else if (i_inc) begin
      w_pc_next = r_pc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_seq.sv
// Fetch/decode/execute sequencer driving a 4-to-16 control decoder.
// Define SINGLE_STEP_EN to add the step_req input (one instruction per pulse).
module instr_seq
  import instr_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
`ifdef SINGLE_STEP_EN
  input  logic              step_req,
`endif
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic [OPC_W-1:0]  dec_sel,
  output logic              dec_valid,
  output logic [3:0]        operand,
  output logic [STEP_W-1:0] step,
  input  logic              exec_done,
  output logic              halted
);

  state_t              r_state;
  logic [7:0]          r_ir;
  logic                r_mem_req;
  logic [OPC_W-1:0]    r_dec_sel;
  logic                r_dec_valid;
  logic [3:0]          r_operand;
  logic [STEP_W-1:0]   r_step;
  logic                r_halted;

  logic                w_start;
  logic                w_pc_inc;
  logic                w_pc_load;
  logic [OPC_W-1:0]    w_opcode;
  logic [ADDR_W-1:0]   w_pc;

`ifdef SINGLE_STEP_EN
  assign w_start = run & step_req;
`else
  assign w_start = run;
`endif

  assign w_opcode  = r_ir[7:4];
  assign w_pc_inc  = (r_state == ST_FETCH) && mem_ack;
  assign w_pc_load = (r_state == ST_DECODE) && (w_opcode == OP_JMP);

  pc_counter u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_pc_load),
    .i_load_val (r_ir[3:0]),
    .i_inc      (w_pc_inc),
    .o_pc       (w_pc)
  );

  // dec_sel/operand load at fetch capture, while dec_valid is still low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ir        <= '0;
      r_mem_req   <= 1'b0;
      r_dec_sel   <= '0;
      r_dec_valid <= 1'b0;
      r_operand   <= '0;
      r_step      <= '0;
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state   <= ST_FETCH;
            r_mem_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (mem_ack) begin
            r_ir      <= mem_data;
            r_dec_sel <= mem_data[7:4];
            r_operand <= mem_data[3:0];
            r_mem_req <= 1'b0;
            r_state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_opcode == OP_HLT) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (w_opcode == OP_JMP) begin
            r_state <= ST_IDLE;
          end else begin
            r_state     <= ST_EXEC;
            r_dec_valid <= 1'b1;
            r_step      <= '0;
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            r_state     <= ST_IDLE;
            r_dec_valid <= 1'b0;
            r_step      <= '0;
          end else begin
            r_step <= satInc(r_step);
          end
        end
        ST_HALT: begin
          r_halted    <= 1'b1;
          r_mem_req   <= 1'b0;
          r_dec_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = w_pc;
  assign dec_sel   = r_dec_sel;
  assign dec_valid = r_dec_valid;
  assign operand   = r_operand;
  assign step      = r_step;
  assign halted    = r_halted;

endmodule

// File: tb/tb_instr_seq.sv
// Scoreboard bench for instr_seq: stimulus pushes expected fetches/decodes,
// a negedge monitor pops and compares; SINGLE_STEP_EN adds the pulse test.
module tb_instr_seq;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       mem_req;
  logic [3:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_data;
  logic [3:0] dec_sel;
  logic       dec_valid;
  logic [3:0] operand;
  logic [2:0] step;
  logic       exec_done;
  logic       halted;
`ifdef SINGLE_STEP_EN
  logic       step_req;
`endif

  instr_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
`ifdef SINGLE_STEP_EN
    .step_req  (step_req),
`endif
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .dec_sel   (dec_sel),
    .dec_valid (dec_valid),
    .operand   (operand),
    .step      (step),
    .exec_done (exec_done),
    .halted    (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] addr;
    int         cycles;
  } fetchExp_t;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] opnd;
  } decExp_t;

  fetchExp_t expFetchQ[$];
  decExp_t   expDecQ[$];

  logic [7:0] mem       [16];
  int         ackDelay  [16];
  int         execLen   [16];
  logic [3:0] lastAddr;
  int         ackWait;
  int         execWait;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushFetch(input logic [3:0] a, input int c);
    fetchExp_t f;
    f.addr   = a;
    f.cycles = c;
    expFetchQ.push_back(f);
  endtask

  task automatic pushDec(input logic [3:0] s, input logic [3:0] o);
    decExp_t d;
    d.sel  = s;
    d.opnd = o;
    expDecQ.push_back(d);
  endtask

  task automatic checkResetState();
    @(negedge clk);
    checkOutput("reset mem_req", mem_req, 0);
    checkOutput("reset mem_addr", mem_addr, 0);
    checkOutput("reset dec_sel", dec_sel, 0);
    checkOutput("reset dec_valid", dec_valid, 0);
    checkOutput("reset operand", operand, 0);
    checkOutput("reset step", step, 0);
    checkOutput("reset halted", halted, 0);
  endtask

  task automatic waitHandshake(input logic [3:0] a, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (mem_req && mem_ack && mem_addr == a) seen = 1;
    end
    checkOutput("handshake reached", {31'd0, seen}, 1);
  endtask

  task automatic waitReq(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (mem_req) seen = 1;
    end
    checkOutput("fetch started", {31'd0, seen}, 1);
  endtask

  // Memory and datapath responders run 2 time units after the edge.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      mem_ack   = 1'b0;
      exec_done = 1'b0;
      ackWait   = 0;
      execWait  = 0;
    end else begin
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (ackWait >= ackDelay[mem_addr]) begin
          mem_ack  = 1'b1;
          mem_data = mem[mem_addr];
          lastAddr = mem_addr;
          ackWait  = 0;
        end else begin
          ackWait++;
        end
      end
      if (exec_done) begin
        exec_done = 1'b0;
      end else if (dec_valid) begin
        if (execWait >= execLen[lastAddr]) begin
          exec_done = 1'b1;
          execWait  = 0;
        end else begin
          execWait++;
        end
      end
    end
  end

  // Monitor: pops scoreboard entries on fetch handshakes and EXEC entry.
  int reqCycles    = 0;
  int execCycle    = 0;
  bit prevDecValid = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      reqCycles    = 0;
      execCycle    = 0;
      prevDecValid = 0;
    end else begin
      if (mem_req) begin
        if (expFetchQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected fetch: mem_addr 0x%0h, required no request", mem_addr);
        end else begin
          reqCycles++;
          checkOutput("fetch mem_addr", mem_addr, expFetchQ[0].addr);
          if (mem_ack) begin
            checkOutput("fetch req cycles", reqCycles, expFetchQ[0].cycles);
            void'(expFetchQ.pop_front());
            reqCycles = 0;
          end
        end
      end
      if (dec_valid && !prevDecValid) begin
        if (expDecQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected exec: dec_sel 0x%0h, required no exec", dec_sel);
        end else begin
          checkOutput("exec dec_sel", dec_sel, expDecQ[0].sel);
          checkOutput("exec operand", operand, expDecQ[0].opnd);
          void'(expDecQ.pop_front());
        end
      end
      if (dec_valid) begin
        checkOutput("exec step", step, (execCycle > 7) ? 7 : execCycle);
        execCycle++;
      end else if (prevDecValid) begin
        checkOutput("step cleared after exec", step, 0);
        execCycle = 0;
      end
      prevDecValid = dec_valid;
    end
  end

  task automatic applyStimulus();
    // Program 1: op, jump, stalled op, jump, op at 15, wrap to 0, halt.
    for (int i = 0; i < 16; i++) begin
      mem[i]      = 8'h00;
      ackDelay[i] = 0;
      execLen[i]  = 0;
    end
    mem[4'h0] = 8'h23; ackDelay[4'h0] = 1; execLen[4'h0] = 2;
    mem[4'h1] = 8'h6C;
    mem[4'hC] = 8'h45; ackDelay[4'hC] = 3; execLen[4'hC] = 0;
    mem[4'hD] = 8'h6F;
    mem[4'hF] = 8'h71; execLen[4'hF] = 1;

    rst_n = 1'b0;
    run   = 1'b1;
`ifdef SINGLE_STEP_EN
    step_req = 1'b1;
`endif
    repeat (3) tick();
    checkResetState();

    pushFetch(4'h0, 2); pushDec(4'h2, 4'h3);
    pushFetch(4'h1, 1);
    pushFetch(4'hC, 4); pushDec(4'h4, 4'h5);
    pushFetch(4'hD, 1);
    pushFetch(4'hF, 1); pushDec(4'h7, 4'h1);
    pushFetch(4'h0, 2);
    tick();
    rst_n = 1'b1;

    waitHandshake(4'hF, 80);
    mem[4'h0] = 8'hF0;

    begin
      bit seenHalt = 0;
      for (int i = 0; i < 40 && !seenHalt; i++) begin
        @(negedge clk);
        if (halted) seenHalt = 1;
      end
      checkOutput("halt reached", {31'd0, seenHalt}, 1);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("halted held", halted, 1);
      checkOutput("halt mem_req", mem_req, 0);
      checkOutput("halt dec_valid", dec_valid, 0);
    end
    checkOutput("program1 fetches drained", expFetchQ.size(), 0);
    checkOutput("program1 execs drained", expDecQ.size(), 0);

    tick();
    rst_n = 1'b0;
    run   = 1'b0;
    tick();
    rst_n = 1'b1;
    checkResetState();

    // Program 2: long EXEC with run dropped, step saturates, no further fetch.
    mem[4'h0] = 8'h5C; ackDelay[4'h0] = 0; execLen[4'h0] = 10;
    pushFetch(4'h0, 1); pushDec(4'h5, 4'hC);
    tick();
    run = 1'b1;
    waitReq(10);
    tick();
    run = 1'b0;
    repeat (30) tick();
    @(negedge clk);
    checkOutput("after exec mem_addr", mem_addr, 1);
    checkOutput("after exec dec_valid", dec_valid, 0);
    checkOutput("after exec mem_req", mem_req, 0);
    checkOutput("program2 drained", expFetchQ.size() + expDecQ.size(), 0);

    // Reset mid-FETCH abandons the fetch without incrementing the PC.
    mem[4'h1] = 8'h30; ackDelay[4'h1] = 10;
    pushFetch(4'h1, 11);
    tick();
    run = 1'b1;
    waitReq(10);
    tick();
    run = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expFetchQ.delete();
    @(negedge clk);
    checkOutput("mid-fetch reset mem_addr", mem_addr, 0);
    checkOutput("mid-fetch reset mem_req", mem_req, 0);

`ifdef SINGLE_STEP_EN
    // Two step_req pulses, 20 cycles apart, each start exactly one fetch.
    mem[4'h0] = 8'h12; ackDelay[4'h0] = 0; execLen[4'h0] = 0;
    mem[4'h1] = 8'h34; ackDelay[4'h1] = 0; execLen[4'h1] = 0;
    tick();
    step_req = 1'b0;
    run      = 1'b1;
    repeat (5) tick();
    pushFetch(4'h0, 1); pushDec(4'h1, 4'h2);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    @(negedge clk);
    checkOutput("step pulse 1 fetch", mem_req, 1);
    repeat (20) tick();
    pushFetch(4'h1, 1); pushDec(4'h3, 4'h4);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    @(negedge clk);
    checkOutput("step pulse 2 fetch", mem_req, 1);
    repeat (20) tick();
    run = 1'b0;
    checkOutput("single-step drained", expFetchQ.size() + expDecQ.size(), 0);
`endif
  endtask

  initial begin
    mem_ack   = 1'b0;
    mem_data  = 8'h00;
    exec_done = 1'b0;
    lastAddr  = 4'h0;
    ackWait   = 0;
    execWait  = 0;
    applyStimulus();
    repeat (2) tick();
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_seq.md
INSTR_SEQ -- requirements
Module: instr_seq

Interface
REQ-001 The block SHALL have the ports `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `rst_n`, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have the port `run`, input, 1 bit: permits starting the next instruction fetch.
REQ-004 The block SHALL have the port `mem_req`, output, 1 bit: instruction fetch request.
REQ-005 The block SHALL have the port `mem_addr`, output, 4 bits: fetch address, equal to the PC.
REQ-006 The block SHALL have the port `mem_ack`, input, 1 bit: fetch data valid this cycle.
REQ-007 The block SHALL have the port `mem_data`, input, 8 bits: instruction byte; [7:4] is the opcode, [3:0] is the operand.
REQ-008 The block SHALL have the port `dec_sel`, output, 4 bits: opcode presented to the downstream 4-to-16 control decoder.
REQ-009 The block SHALL have the port `dec_valid`, output, 1 bit: `dec_sel` is live and the decoded line may act.
REQ-010 The block SHALL have the port `operand`, output, 4 bits: the low nibble of the current instruction.
REQ-011 The block SHALL have the port `step`, output, 3 bits: microstep count within EXEC.
REQ-012 The block SHALL have the port `exec_done`, input, 1 bit: the datapath has finished the current instruction.
REQ-013 The block SHALL have the port `halted`, output, 1 bit: the HLT instruction has been executed.

Function
REQ-014 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC and HALT, and all outputs SHALL be registered.
REQ-015 In IDLE with run=1, the FSM SHALL enter FETCH on the next edge; with run=0 it SHALL remain in IDLE.
REQ-016 In FETCH, the block SHALL hold mem_req=1 and hold mem_addr=PC stable until mem_ack=1.
REQ-017 On the FETCH cycle with mem_ack=1, the block SHALL capture mem_data into the instruction register, set PC to PC+1 modulo 16 (15 wraps to 0), drop mem_req, and enter DECODE.
REQ-018 The block SHALL ignore mem_ack and mem_data in every state other than FETCH.
REQ-019 DECODE SHALL last exactly one cycle, with these transitions:
  - opcode OP_HLT (4'hF) SHALL go to HALT;
  - opcode OP_JMP (4'h6) SHALL load PC with the operand and go to IDLE, without entering EXEC;
  - every other opcode SHALL go to EXEC.
REQ-020 In EXEC, the block SHALL hold dec_valid=1 and dec_sel=opcode, and dec_sel SHALL change only while dec_valid=0.
REQ-021 The step output SHALL be 0 on the first EXEC cycle, increment by 1 each cycle, and saturate at 7.
REQ-022 exec_done=1 in EXEC SHALL send the FSM to IDLE; dec_valid and step SHALL be 0 on the next cycle.
REQ-023 EXEC SHALL last at least one cycle, and exec_done=1 on the first EXEC cycle SHALL be honoured.
REQ-024 run SHALL be sampled only in IDLE; deasserting run mid-instruction SHALL let the current instruction complete.
REQ-025 In HALT, the block SHALL hold halted=1, mem_req=0 and dec_valid=0, and the FSM SHALL leave HALT only through reset.
REQ-026 The minimum instruction time SHALL be 4 cycles: IDLE, FETCH with a same-cycle ack, DECODE, and one EXEC cycle.

Reset
REQ-027 While rst_n=0 at a rising edge, the block SHALL set state=IDLE, PC=0, IR=0, mem_req=0, mem_addr=0, dec_sel=0, dec_valid=0, operand=0, step=0 and halted=0.
REQ-028 Reset in any state, including mid-FETCH or HALT, SHALL abandon the instruction in flight, with no PC increment.

Configuration
REQ-029 With SINGLE_STEP_EN defined, the block SHALL add the 1-bit input step_req, and IDLE SHALL go to FETCH only when run=1 and step_req=1 in the same cycle, giving one instruction per pulse.
REQ-030 With SINGLE_STEP_EN undefined, the step_req port SHALL be absent and the IDLE transition SHALL depend on run alone.

Structure
REQ-031 Package instr_seq_pkg SHALL hold:
  - the state enum;
  - OP_JMP and OP_HLT;
  - the widths ADDR_W=4, OPC_W=4 and STEP_W=3.
REQ-032 The PC (load, increment, wrap) SHALL be a sub-module named pc_counter, instantiated once.

Verification
REQ-033 Reset and single fetch: release reset with run=1, mem_data=8'h23 and an ack one cycle after req -> mem_addr=0 during FETCH, dec_sel=4'h2, operand=4'h3, dec_valid high in EXEC, then PC=1.
REQ-034 Ack stall: hold mem_ack low for 3 cycles -> mem_req and mem_addr stay constant for 4 cycles, and exactly one PC increment occurs.
REQ-035 Jump: mem_data=8'h6A -> dec_valid never rises, and the next mem_addr is 4'hA.
REQ-036 Wrap and halt: a PC=15 fetch -> the next fetch address is 0; mem_data=8'hF0 -> halted=1 stays high for 20 cycles with mem_req=0 and is cleared by rst_n=0.
REQ-037 Step saturation and run drop: hold exec_done low for 10 EXEC cycles with run=0 -> step reads 0..7 then stays at 7; after exec_done the FSM stays in IDLE with no further mem_req.
REQ-038 SINGLE_STEP_EN: run=1 with two step_req pulses 20 cycles apart -> exactly two fetches occur, each starting one cycle after its pulse.
